// File: rtl/simt_mask_stack_if.sv
// simt_mask_stack_if: bundle between the control unit / fetch logic and the
// SIMT divergence stack. Optional statistics signals exist only when
// SIMT_STACK_STATS_EN is defined.
//
// Command semantics: pushEn / writeSync are commands that the stack accepts
// in every cycle where en=1. There is no backpressure. With en=0 the command
// is ignored and redir reads 0. redir/redir_pc are only meaningful in the
// same cycle as an accepted writeSync.
interface simt_mask_stack_if #(
  parameter int THREADS = 4,
  parameter int DEPTH   = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic               en;
  logic               pushEn;
  logic               writeSync;
  logic [THREADS-1:0] vbrEn;
  logic [31:0]        npc;

  logic [THREADS-1:0] mask;
  logic               redir;
  logic [31:0]        redir_pc;
  logic [DW-1:0]      depth;
  logic               empty;
  logic               full;
  logic               ovf;
  logic               top_pending;  // debug: top entry is in PENDING state
`ifdef SIMT_STACK_STATS_EN
  logic [31:0]        div_cnt;
  logic [DW-1:0]      max_depth;

  modport master (
    output en, pushEn, writeSync, vbrEn, npc,
    input  mask, redir, redir_pc, depth, empty, full, ovf, top_pending,
    input  div_cnt, max_depth
  );
  modport slave (
    input  en, pushEn, writeSync, vbrEn, npc,
    output mask, redir, redir_pc, depth, empty, full, ovf, top_pending,
    output div_cnt, max_depth
  );
`else
  modport master (
    output en, pushEn, writeSync, vbrEn, npc,
    input  mask, redir, redir_pc, depth, empty, full, ovf, top_pending
  );
  modport slave (
    input  en, pushEn, writeSync, vbrEn, npc,
    output mask, redir, redir_pc, depth, empty, full, ovf, top_pending
  );
`endif
endinterface

// File: rtl/simt_mask_stack.sv
// simt_mask_stack: divergence/reconvergence controller for the SIMT lanes.
// Owns the active lane mask. A divergent vector branch pushes the deferred
// not-taken path. SYNC first switches to the deferred path with a fetch
// redirect, then on the second SYNC pops back to the pre-branch mask.
// Optional feature macro: SIMT_STACK_STATS_EN (divergence counter and
// depth high-water mark).
module simt_mask_stack #(
  parameter int THREADS = 4,
  parameter int DEPTH   = 8
) (
  input logic               CLK,
  input logic               nRST,
  simt_mask_stack_if.slave  bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic {
    ENT_PENDING = 1'b0,
    ENT_RECONV  = 1'b1
  } ent_state_e;

  // Control state (reset)
  logic [THREADS-1:0] mask_q, mask_d;
  logic [DW-1:0]      depth_q, depth_d;
  logic               ovf_q, ovf_d;
  ent_state_e         st_q [DEPTH];
  ent_state_e         st_d [DEPTH];

  // Entry payload (no reset, only meaningful below depth_q)
  logic [THREADS-1:0] pend_mask_q [DEPTH];
  logic [31:0]        pend_pc_q   [DEPTH];
  logic [THREADS-1:0] rest_mask_q [DEPTH];

  logic               wr_en;
  logic [IW-1:0]      wr_idx;
  logic [IW-1:0]      top_idx;
  logic [THREADS-1:0] taken;
  logic [THREADS-1:0] not_taken;
  logic               divergent;
  logic               empty_w;
  logic               full_w;
  logic               top_pend;
  logic               sync_go;

  assign taken     = bus.vbrEn;
  assign not_taken = mask_q & ~taken;
  // Both sides non-empty means the warp actually splits.
  assign divergent = (taken != '0) && (not_taken != '0);
  assign empty_w   = (depth_q == '0);
  assign full_w    = (depth_q == DW'(DEPTH));
  // Top pointer is depth-1 with no wrap; unused when empty.
  assign top_idx   = IW'(depth_q - DW'(1));
  assign wr_idx    = IW'(depth_q);
  assign top_pend  = !empty_w && (st_q[top_idx] == ENT_PENDING);
  // pushEn has priority, so a coincident writeSync is dropped.
  assign sync_go   = bus.en && bus.writeSync && !bus.pushEn && !empty_w;

  // Next-state: push on divergent branch, switch/pop on SYNC, hold otherwise
  always_comb begin
    mask_d  = mask_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    st_d    = st_q;
    wr_en   = 1'b0;
    if (bus.en) begin
      if (bus.pushEn) begin
        if (divergent) begin
          if (full_w) begin
            // No room: drop the entry, keep mask, flag the error.
            ovf_d = 1'b1;
          end else begin
            wr_en          = 1'b1;
            st_d[wr_idx]   = ENT_PENDING;
            mask_d         = taken;
            depth_d        = depth_q + DW'(1);
          end
        end
      end else if (sync_go) begin
        if (top_pend) begin
          mask_d        = pend_mask_q[top_idx];
          st_d[top_idx] = ENT_RECONV;
        end else begin
          mask_d        = rest_mask_q[top_idx];
          st_d[top_idx] = ENT_RECONV;
          depth_d       = depth_q - DW'(1);
        end
      end
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mask_q  <= '1;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i] <= ENT_RECONV;
      end
    end else begin
      mask_q  <= mask_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      st_q    <= st_d;
    end
  end

  // Entry payload write on an accepted push
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      pend_mask_q[wr_idx] <= not_taken;
      pend_pc_q[wr_idx]   <= bus.npc;
      rest_mask_q[wr_idx] <= mask_q;
    end
  end

  assign bus.mask        = mask_q;
  assign bus.depth       = depth_q;
  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.ovf         = ovf_q;
  assign bus.top_pending = top_pend;
  assign bus.redir       = sync_go && top_pend;
  assign bus.redir_pc    = pend_pc_q[top_idx];

`ifdef SIMT_STACK_STATS_EN
  logic [31:0]   div_cnt_q, div_cnt_d;
  logic [DW-1:0] max_depth_q, max_depth_d;

  // Statistics next-state: saturating divergence count and depth high-water
  always_comb begin
    div_cnt_d   = div_cnt_q;
    max_depth_d = max_depth_q;
    if (bus.en) begin
      if (bus.pushEn && divergent && (div_cnt_q != '1)) begin
        div_cnt_d = div_cnt_q + 32'd1;
      end
      if (depth_d > max_depth_q) begin
        max_depth_d = depth_d;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      div_cnt_q   <= '0;
      max_depth_q <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      max_depth_q <= max_depth_d;
    end
  end

  assign bus.div_cnt   = div_cnt_q;
  assign bus.max_depth = max_depth_q;
`endif
endmodule

// File: tb/tb_simt_mask_stack.sv
// tb_simt_mask_stack: table-driven bench for simt_mask_stack with a
// scoreboard queue holding the expected registered state after each step.
module tb_simt_mask_stack;
  localparam int THREADS = 4;
  localparam int DEPTH   = 8;
  localparam int W       = 11;  // {mask[4], depth[4], empty, full, ovf}

  logic CLK;
  logic nRST;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  simt_mask_stack_if #(.THREADS(THREADS), .DEPTH(DEPTH)) bus_if ();

  simt_mask_stack #(.THREADS(THREADS), .DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus_if.slave)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en;
    logic        push;
    logic        sync;
    logic [3:0]  vbr;
    logic [31:0] npc;
    logic        redir;
    logic [31:0] rpc;
    logic [3:0]  mask;
    logic [3:0]  depth;
    logic        ovf;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mkv(input logic en, input logic push, input logic sync,
                               input logic [3:0] vbr, input logic [31:0] npc,
                               input logic redir, input logic [31:0] rpc,
                               input logic [3:0] mask, input logic [3:0] depth,
                               input logic ovf);
    vec_t v;
    v.en = en; v.push = push; v.sync = sync; v.vbr = vbr; v.npc = npc;
    v.redir = redir; v.rpc = rpc; v.mask = mask; v.depth = depth; v.ovf = ovf;
    return v;
  endfunction

  // Pop one expectation and compare against the registered outputs
  task automatic check_state(input string name);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    act_v = {bus_if.mask, bus_if.depth, bus_if.empty, bus_if.full, bus_if.ovf};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, actual %b", name, act_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s state {mask,depth,empty,full,ovf}: actual %b required %b",
                 name, act_v, exp_v);
      end
    end
  endtask

  // Drive one cycle, check combinational redirect, then post-edge state
  task automatic step(input logic en, input logic push, input logic sync,
                      input logic [3:0] vbr, input logic [31:0] npc,
                      input logic exp_redir, input logic [31:0] exp_pc,
                      input logic [3:0] exp_mask, input logic [3:0] exp_depth,
                      input logic exp_ovf, input string name);
    @(negedge CLK);
    bus_if.en        = en;
    bus_if.pushEn    = push;
    bus_if.writeSync = sync;
    bus_if.vbrEn     = vbr;
    bus_if.npc       = npc;
    #1;
    checks++;
    if (bus_if.redir !== exp_redir || (exp_redir && bus_if.redir_pc !== exp_pc)) begin
      errors++;
      $display("FAIL %s redir: actual %b pc %h required %b pc %h",
               name, bus_if.redir, bus_if.redir_pc, exp_redir, exp_pc);
    end
    exp_q.push_back({exp_mask, exp_depth, exp_depth == 4'd0,
                     exp_depth == 4'(DEPTH), exp_ovf});
    @(posedge CLK);
    #1;
    check_state(name);
  endtask

  task automatic do_reset(input int cycles, input string name);
    @(negedge CLK);
    nRST             = 1'b0;
    bus_if.en        = 1'b1;
    bus_if.pushEn    = 1'b0;
    bus_if.writeSync = 1'b0;
    bus_if.vbrEn     = '0;
    bus_if.npc       = '0;
    exp_q.push_back({4'b1111, 4'd0, 1'b1, 1'b0, 1'b0});
    repeat (cycles) @(posedge CLK);
    #1;
    check_state(name);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    logic [3:0]  r_vbr;
    logic [31:0] r_npc;
    logic [3:0]  ov_t;
    logic [3:0]  ov_mask;

    nRST             = 1'b0;
    bus_if.en        = 1'b0;
    bus_if.pushEn    = 1'b0;
    bus_if.writeSync = 1'b0;
    bus_if.vbrEn     = '0;
    bus_if.npc       = '0;

    //              en push sync vbr     npc        redir rpc        mask     depth ovf
    vecs[0]  = mkv(1, 1, 0, 4'b0011, 32'h40,  0, 32'h0,  4'b0011, 4'd1, 0);  // divergent push
    vecs[1]  = mkv(1, 0, 1, 4'b0000, 32'h100, 1, 32'h40, 4'b1100, 4'd1, 0);  // SYNC to deferred path
    vecs[2]  = mkv(1, 0, 1, 4'b0000, 32'h104, 0, 32'h0,  4'b1111, 4'd0, 0);  // SYNC pop
    vecs[3]  = mkv(1, 1, 0, 4'b1111, 32'h50,  0, 32'h0,  4'b1111, 4'd0, 0);  // uniform all taken
    vecs[4]  = mkv(1, 1, 0, 4'b0000, 32'h54,  0, 32'h0,  4'b1111, 4'd0, 0);  // uniform none taken
    vecs[5]  = mkv(1, 1, 0, 4'b0111, 32'h80,  0, 32'h0,  4'b0111, 4'd1, 0);  // outer push
    vecs[6]  = mkv(1, 1, 0, 4'b0001, 32'h90,  0, 32'h0,  4'b0001, 4'd2, 0);  // inner push
    vecs[7]  = mkv(1, 0, 1, 4'b0000, 32'h200, 1, 32'h90, 4'b0110, 4'd2, 0);
    vecs[8]  = mkv(1, 0, 1, 4'b0000, 32'h204, 0, 32'h0,  4'b0111, 4'd1, 0);
    vecs[9]  = mkv(1, 0, 1, 4'b0000, 32'h208, 1, 32'h80, 4'b1000, 4'd1, 0);
    vecs[10] = mkv(1, 0, 1, 4'b0000, 32'h20C, 0, 32'h0,  4'b1111, 4'd0, 0);
    vecs[11] = mkv(0, 1, 0, 4'b0011, 32'h60,  0, 32'h0,  4'b1111, 4'd0, 0);  // stall with push
    vecs[12] = mkv(1, 0, 1, 4'b0000, 32'h64,  0, 32'h0,  4'b1111, 4'd0, 0);  // SYNC on empty
    vecs[13] = mkv(1, 1, 1, 4'b0101, 32'hA0,  0, 32'h0,  4'b0101, 4'd1, 0);  // push beats sync
    vecs[14] = mkv(0, 0, 1, 4'b0000, 32'hB0,  0, 32'h0,  4'b0101, 4'd1, 0);  // stalled SYNC
    vecs[15] = mkv(1, 0, 1, 4'b0000, 32'hB4,  1, 32'hA0, 4'b1010, 4'd1, 0);
    vecs[16] = mkv(1, 0, 1, 4'b0000, 32'hB8,  0, 32'h0,  4'b1111, 4'd0, 0);
    vecs[17] = mkv(1, 0, 0, 4'b0000, 32'hBC,  0, 32'h0,  4'b1111, 4'd0, 0);  // idle

    do_reset(2, "reset");

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].en, vecs[i].push, vecs[i].sync, vecs[i].vbr, vecs[i].npc,
           vecs[i].redir, vecs[i].rpc, vecs[i].mask, vecs[i].depth, vecs[i].ovf,
           $sformatf("vec%0d", i));
    end

    // Random divergent branch then two SYNCs from a full mask
    for (int i = 0; i < 3; i++) begin
      r_vbr = 4'($urandom_range(1, 14));
      r_npc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step(1, 1, 0, r_vbr, r_npc, 0, 32'h0, r_vbr, 4'd1, 0, $sformatf("rnd%0d_push", i));
      step(1, 0, 1, 4'b0, 32'h300, 1, r_npc, ~r_vbr, 4'd1, 0, $sformatf("rnd%0d_sync1", i));
      step(1, 0, 1, 4'b0, 32'h304, 0, 32'h0, 4'b1111, 4'd0, 0, $sformatf("rnd%0d_sync2", i));
    end

    // Overflow: nine divergent pushes. Four lanes cannot nest eight deep
    // with taken masks that are subsets, so the taken lane alternates
    // between lane 0 and lane 1 to keep every push divergent.
    ov_mask = 4'b1111;
    for (int i = 1; i <= 8; i++) begin
      ov_t = (i % 2 == 1) ? 4'b0001 : 4'b0010;
      step(1, 1, 0, ov_t, 32'h400 + 32'(i), 0, 32'h0, ov_t, 4'(i), 0,
           $sformatf("ovf_push%0d", i));
      ov_mask = ov_t;
    end
    step(1, 1, 0, 4'b0001, 32'h500, 0, 32'h0, ov_mask, 4'd8, 1, "ovf_push9");
    step(1, 0, 0, 4'b0000, 32'h504, 0, 32'h0, ov_mask, 4'd8, 1, "ovf_sticky");
    // Top entry is pending with lanes of push 8 (not-taken = 0001)
    step(1, 0, 1, 4'b0000, 32'h508, 1, 32'h408, 4'b0001, 4'd8, 1, "ovf_sync_from_full");
    step(1, 0, 1, 4'b0000, 32'h50C, 0, 32'h0, 4'b0001, 4'd7, 1, "ovf_pop_from_full");

`ifdef SIMT_STACK_STATS_EN
    // 4 table pushes + 3 random + 9 overflow sequence; peak depth 8
    checks++;
    if (bus_if.div_cnt !== 32'd16 || bus_if.max_depth !== 4'd8) begin
      errors++;
      $display("FAIL stats: actual div_cnt %0d max_depth %0d required 16 8",
               bus_if.div_cnt, bus_if.max_depth);
    end
`endif

    // Reset mid-divergence clears everything in one cycle
    do_reset(1, "reset_mid");
    step(1, 0, 1, 4'b0000, 32'h600, 0, 32'h0, 4'b1111, 4'd0, 0, "post_reset_sync");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
